// File: rtl/fir_in_pkg.sv
// Shared constants for the FIR sample feeder.
//   DATA_W    : width of one switch sample
//   DEPTH_DEF : default number of sample FIFO entries
//   PTR_W     : FIFO pointer width for the default depth
package fir_in_pkg;
  localparam int DATA_W    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
endpackage

// File: rtl/fir_sample_feeder_if.sv
// Sample handshake between the feeder and the FIR stage.
//   sample_data  : FIFO head sample (feeder -> FIR)
//   sample_valid : head holds an unconsumed sample (feeder -> FIR)
//   sample_ready : FIR accepts a sample this cycle (FIR -> feeder)
//   count        : samples currently stored (feeder -> FIR)
//   overflow     : sticky, a capture was dropped (feeder -> FIR)
interface fir_sample_feeder_if
  import fir_in_pkg::*;
#(
  parameter int PW = PTR_W
) ();
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic [PW:0]       count;
  logic              overflow;

  modport master (
    output sample_data, sample_valid, count, overflow,
    input  sample_ready
  );

  modport slave (
    input  sample_data, sample_valid, count, overflow,
    output sample_ready
  );
endinterface

// File: rtl/debounce_onepulse.sv
// Synchronizes the raw push-button, debounces it and emits one registered
// pulse per accepted 0->1 transition of the debounced level.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   go_raw : raw asynchronous, bouncy button
//   pulse  : one-cycle capture strobe, one per debounced press
module debounce_onepulse #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic go_raw,
  output logic pulse
);
  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_go_p0;
  logic          r_go_p1;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          w_differ;
  logic          w_expire;

  assign w_differ = r_go_p1 ^ r_level;
  // The level flips only after the synchronized input has disagreed with it
  // on DEBOUNCE_CYCLES consecutive edges.
  assign w_expire = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_go_p0 <= 1'b0;
      r_go_p1 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizer
      r_go_p0 <= go_raw;
      r_go_p1 <= r_go_p0;
      // Debounce: any agreeing cycle restarts the stability window
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Registered strobe on the rising toggle only; releases are silent
      r_pulse <= w_expire && !r_level;
    end
  end

  assign pulse = r_pulse;
endmodule

// File: rtl/fir_sample_feeder.sv
// Captures the switch value on each debounced button press and queues it in
// a small FIFO that feeds the FIR stage through a valid/ready handshake.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (clears control, discards samples)
//   in   : asynchronous switch sample value
//   go   : raw asynchronous bouncy push-button
//   bus  : sample handshake (data/valid/count/overflow out, ready in)
module fir_sample_feeder
  import fir_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = DEPTH_DEF   // power of two, at least 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              go,
  fir_sample_feeder_if.master bus
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] r_in_p0;
  logic [DATA_W-1:0] r_in_p1;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic              r_overflow;
  logic              w_capture;
  logic              w_full;
  logic              w_pop;
  logic              w_accept;

  // Power-of-two depth, so natural pointer rollover is the modulo wrap.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + 1'b1;
  endfunction

  debounce_onepulse #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .go_raw (go),
    .pulse  (w_capture)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_p0 <= '0;
      r_in_p1 <= '0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizer for the switch value
      r_in_p0 <= in;
      r_in_p1 <= r_in_p0;
    end
  end

  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = (r_count != '0) && bus.sample_ready;
  // A full FIFO still takes the capture when the head leaves the same cycle.
  assign w_accept = w_capture && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_mem[r_wr_ptr] <= r_in_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_capture && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Outputs come straight from registered state; ready only steers the update.
  assign bus.sample_data  = r_mem[r_rd_ptr];
  assign bus.sample_valid = (r_count != '0);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;
  import fir_in_pkg::*;

  localparam int D     = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_v;
  logic              go;

  int checks = 0;
  int errors = 0;

  fir_sample_feeder_if bus ();

  fir_sample_feeder #(
    .DEBOUNCE_CYCLES(D),
    .DEPTH          (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in_v),
    .go  (go),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  // Synchronizers are plain two-deep delay lines; the debounced level flips
  // when the last D synchronized samples all disagree with it; a rising flip
  // deposits the synchronized switch value one edge later.
  bit          go_dly [2];
  logic [7:0]  in_dly [2];
  bit          hist [$];
  bit          lvl;
  bit          pend;
  logic [7:0]  q [$];
  bit          ovf;
  bit          rst_edge;

  always @(posedge clk) begin : model
    bit pop;
    bit all_diff;
    rst_edge = rst;
    if (rst) begin
      go_dly = '{1'b0, 1'b0};
      in_dly = '{8'h00, 8'h00};
      hist.delete();
      lvl  = 1'b0;
      pend = 1'b0;
      q.delete();
      ovf  = 1'b0;
    end else begin
      pop = (q.size() != 0) && bus.sample_ready;
      if (pop) void'(q.pop_front());
      if (pend) begin
        if (q.size() < DEPTH) q.push_back(in_dly[1]);
        else ovf = 1'b1;
      end
      hist.push_back(go_dly[1]);
      if (hist.size() > D) void'(hist.pop_front());
      pend = 1'b0;
      if (hist.size() == D) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i] == lvl) all_diff = 1'b0;
        if (all_diff) begin
          lvl  = !lvl;
          pend = lvl;
          hist.delete();
        end
      end
      go_dly[1] = go_dly[0];
      go_dly[0] = go;
      in_dly[1] = in_dly[0];
      in_dly[0] = in_v;
    end
  end

  // Per-cycle scoreboard plus stall-stability check
  bit         p_valid = 1'b0;
  bit         p_ready = 1'b0;
  logic [7:0] p_data  = 8'h00;

  always @(posedge clk) begin
    #2;
    chk("sb_valid", int'(bus.sample_valid), int'(q.size() != 0));
    chk("sb_count", int'(bus.count), q.size());
    chk("sb_overflow", int'(bus.overflow), int'(ovf));
    if (q.size() != 0) chk("sb_data", int'(bus.sample_data), int'(q[0]));
    if (p_valid && !p_ready && !rst_edge)
      chk("stall_hold", int'(bus.sample_data), int'(p_data));
    p_valid = bus.sample_valid;
    p_ready = bus.sample_ready;
    p_data  = bus.sample_data;
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [7:0] v);
    in_v = v;
    go   = 1'b1;
    repeat (D + 8) step();
    go = 1'b0;
    repeat (D + 6) step();
  endtask

  task automatic take(input logic [7:0] exp);
    chk("take_valid", int'(bus.sample_valid), 1);
    chk("take_data", int'(bus.sample_data), int'(exp));
    bus.sample_ready = 1'b1;
    step();
    bus.sample_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] val;
    int         exp_count;
    bit         exp_ovf;
    logic [7:0] exp_head;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] sent [$];

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'd1, 1, 1'b0, 8'd1};
    tbl[1] = '{8'd2, 2, 1'b0, 8'd1};
    tbl[2] = '{8'd3, 3, 1'b0, 8'd1};
    tbl[3] = '{8'd4, 4, 1'b0, 8'd1};
    tbl[4] = '{8'd5, 4, 1'b1, 8'd1};

    rst = 1'b1; go = 1'b0; in_v = 8'h00; bus.sample_ready = 1'b0;
    repeat (3) step();
    chk("reset_valid", int'(bus.sample_valid), 0);
    chk("reset_count", int'(bus.count), 0);
    chk("reset_overflow", int'(bus.overflow), 0);
    rst = 1'b0;

    // Clean press: valid rises exactly at edge D+3 (edge 19)
    in_v = 8'h2A;
    go   = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == D + 2) chk("clean_valid_before_19", int'(bus.sample_valid), 0);
      if (e == D + 3) begin
        chk("clean_valid_edge19", int'(bus.sample_valid), 1);
        chk("clean_data", int'(bus.sample_data), 8'h2A);
        chk("clean_count", int'(bus.count), 1);
      end
    end
    go = 1'b0;
    repeat (D + 6) step();
    chk("clean_single_capture", int'(bus.count), 1);
    take(8'h2A);

    // Bounce: toggle every 5 cycles for 50 cycles, then hold high
    in_v = 8'h5C;
    for (int k = 0; k < 10; k++) begin
      go = (k % 2 == 0);
      repeat (5) step();
    end
    chk("bounce_no_capture", int'(bus.count), 0);
    go = 1'b1;
    for (int e = 1; e <= D + 10; e++) begin
      step();
      if (e == D + 2) chk("bounce_before", int'(bus.count), 0);
      if (e == D + 3) chk("bounce_capture", int'(bus.count), 1);
    end
    go = 1'b0;
    repeat (D + 6) step();
    chk("bounce_single", int'(bus.count), 1);
    take(8'h5C);

    // Full and overflow, table driven
    foreach (tbl[i]) begin
      press(tbl[i].val);
      chk("tbl_count", int'(bus.count), tbl[i].exp_count);
      chk("tbl_overflow", int'(bus.overflow), int'(tbl[i].exp_ovf));
      chk("tbl_head", int'(bus.sample_data), int'(tbl[i].exp_head));
    end
    for (int v = 1; v <= 4; v++) take(8'(v));
    chk("drain_empty", int'(bus.count), 0);
    chk("overflow_sticky", int'(bus.overflow), 1);

    // Reset mid-operation with three samples stored and overflow set
    press(8'd7); press(8'd8); press(8'd9);
    chk("pre_reset_count", int'(bus.count), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_count", int'(bus.count), 0);
    chk("midreset_valid", int'(bus.sample_valid), 0);
    chk("midreset_overflow", int'(bus.overflow), 0);

    // Button held through reset release counts as one new press
    in_v = 8'h33;
    go   = 1'b1;
    rst  = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (D + 8) step();
    chk("held_reset_capture", int'(bus.count), 1);
    go = 1'b0;
    repeat (D + 6) step();
    chk("held_reset_single", int'(bus.count), 1);
    take(8'h33);

    // Capture while full with a same-cycle transfer
    for (int v = 1; v <= 4; v++) press(8'(v));
    in_v = 8'h09;
    go   = 1'b1;
    for (int e = 1; e <= D + 8; e++) begin
      step();
      if (e == D + 2) begin
        chk("simul_pre_count", int'(bus.count), 4);
        bus.sample_ready = 1'b1;
      end
      if (e == D + 3) begin
        bus.sample_ready = 1'b0;
        chk("simul_count", int'(bus.count), 4);
        chk("simul_overflow", int'(bus.overflow), 0);
        chk("simul_head", int'(bus.sample_data), 2);
      end
    end
    go = 1'b0;
    repeat (D + 6) step();
    take(8'd2); take(8'd3); take(8'd4); take(8'h09);
    chk("simul_overflow_end", int'(bus.overflow), 0);

    // Backpressure and wrap-around with random data and random ready
    for (int n = 0; n < 10; n++) begin
      in_v = 8'($urandom);
      sent.push_back(in_v);
      go = 1'b1;
      for (int c = 0; c < 2 * D + 14; c++) begin
        if (c == D + 8) go = 1'b0;
        bus.sample_ready = 1'($urandom_range(0, 1));
        if (bus.sample_valid && bus.sample_ready) begin
          if (sent.size() == 0) chk("order_extra", 1, 0);
          else chk("order_data", int'(bus.sample_data), int'(sent.pop_front()));
        end
        step();
      end
    end
    for (int c = 0; c < 8; c++) begin
      bus.sample_ready = 1'b1;
      if (bus.sample_valid) begin
        if (sent.size() == 0) chk("order_extra", 1, 0);
        else chk("order_data", int'(bus.sample_data), int'(sent.pop_front()));
      end
      step();
    end
    bus.sample_ready = 1'b0;
    chk("wrap_all_drained", sent.size(), 0);
    chk("wrap_count", int'(bus.count), 0);
    chk("wrap_overflow", int'(bus.overflow), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
